note_highway: RTL and testbench
===============================

# note_highway

Parametrised note-lane engine for the Guitar Hero VGA display. It sits between the game sequencer/processor and the VGA pixel mux, and owns all falling-note state. It keeps up to SLOTS notes in each of LANES lanes, advances them once per frame at a programmable speed, and judges strums against the hit bar. It also reports hits and misses and tags each pixel for the colour mux. It generalises the fixed 4×4 note arrays with free-running positions into allocate/retire slots with real hit/miss judgement.

## Interface
- LANES, 4: number of lanes (1..8)
- SLOTS, 4: note slots per lane (1..16)
- Y_W, 10: note-position width (unsigned)
- SCREEN_H, 480: notes at or past this y retire
- LANE_X0, 170: x of lane 0 left edge
- LANE_PITCH, 100: x spacing between lanes
- NOTE_W, 50: note square size
- BAR_Y, 350: hit-bar top
- BAR_H, 20: hit-bar height
- clk  in  1  100 MHz system clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per movement step
- speed  in  4  pixels advanced per frame_tick (0 = frozen)
- spawn_valid  in  1  spawn request
- spawn_lanes  in  LANES  lanes receiving a new note
- spawn_ready  out  1  all requested lanes have a free slot
- strum  in  1  one-cycle strum pulse (already debounced)
- frets  in  LANES  held fret buttons
- x  in  10  current pixel column
- y  in  9  current pixel row
- pix_note  out  1  pixel inside an active note (registered)
- pix_lane  out  3  lane of that note (lowest lane wins)
- pix_bar  out  1  pixel inside the hit bar (registered)
- hit_pulse  out  1  one-cycle pulse: ≥1 lane hit
- hit_mask  out  LANES  lanes hit, valid with hit_pulse
- miss_pulse  out  1  one-cycle pulse: ≥1 lane missed
- miss_mask  out  LANES  lanes missed, valid with miss_pulse
- hit_count  out  16  saturating total hits
- miss_count  out  16  saturating total misses

## Operation
- Per slot: active bit and pos[Y_W-1:0] (top edge).
- Spawn: the transfer fires when spawn_valid && spawn_ready. In each requested lane, the lowest-index free slot becomes active with pos=0.
- spawn_ready = !reset && every lane in spawn_lanes has ≥1 free slot. spawn_lanes=0 is always ready and does nothing.
- Move: on frame_tick, each active slot computes pos+speed in Y_W+1 bits. If the sum ≥ SCREEN_H, the slot retires and is counted as a miss in its lane (fall-off). Otherwise pos takes the sum.
- In-window: an active slot is in-window when pos+NOTE_W > BAR_Y && pos < BAR_Y+BAR_H.
- Strum: on strum, each lane with its fret bit set is judged.
  - If the lane has an in-window slot, the lowest-index such slot is cleared and the lane is a hit.
  - Otherwise the lane is a miss.
  - Lanes with the fret bit clear are not judged. A strum with frets=0 has no effect.
- Simultaneous events in one cycle are ordered as follows:
  - The strum is judged on the pre-move positions.
  - Surviving slots then move.
  - The spawned note is written last, with pos=0 and no move applied.
  - A slot hit by the strum cannot also fall-off miss.
- miss_mask = strum-miss lanes | fall-off lanes from the same cycle.
- Counters: hit_count adds popcount(hit_mask) and miss_count adds popcount(miss_mask). Both saturate at 16'hFFFF.
- Pixel tag: a lane L note covers x in [LANE_X0+L·LANE_PITCH, +NOTE_W) and y in [pos, pos+NOTE_W), compared at Y_W+1 bits. The bar covers x in [LANE_X0-50, LANE_X0+(LANES-1)·LANE_PITCH+NOTE_W+50) and y in [BAR_Y, BAR_Y+BAR_H).

## Timing
- Reset (synchronous) clears all slots, both counters, and all pulse/mask/pixel outputs to 0. spawn_ready is 0 while reset is high.
- Reset mid-frame discards all notes. No miss is reported for notes cleared by reset.
- Slot state updates on the edge that samples strum/frame_tick/spawn.
- hit_pulse, miss_pulse and the masks are registered: they assert the cycle after the causing event and last exactly 1 cycle. The counters update on the same edge.
- Pixel outputs have 1-cycle latency from x/y. The VGA mux delays its active signal to match.
- spawn_ready is combinational from the current slot state. It does not reflect frees happening in the same cycle.

## Structure
- note_highway_pkg holds:
  - screen constants (SCREEN_H, bar geometry defaults);
  - the popcount function;
  - the slot record (active, pos).
- Sub-module note_lane holds one lane's SLOTS slots, free-slot priority encoder, in-window detect, move/retire and pixel compare. It outputs free, hit, falloff and pix_hit. note_highway instantiates note_lane LANES times and adds the counters, output registers and bar/pixel merge.

## Test plan
- Reset, spawn lanes=4'b0001, speed=5: after 70 ticks, lane 0 pos=350, in-window; strum with frets=0001 → hit_pulse=1, hit_mask=0001 one cycle later, hit_count=1, slot freed.
- Strum with frets=0010 and no lane-1 note → miss_mask=0010, miss_count=1, no slot change.
- Fill lane 2 with SLOTS spawns → spawn_ready=0 for lanes=0100, ready still 1 for lanes=0001; spawn_valid held while not ready creates no note.
- Lane-3 note at pos=478, speed=5, frame_tick → retires, miss_mask=1000; in the same cycle, a strum hit on lane 0 gives hit_mask=0001 and miss_mask=1000 together.
- Note with pos=345, strum and frame_tick in the same cycle, frets matching → hit, judged on pos 345. Preload miss_count=16'hFFFE, two misses → counter holds at 16'hFFFF.
- Pixel: note at pos=100 in lane 1, x=270, y=100 → pix_note=1 and pix_lane=1 one cycle later; x=320 → pix_note=0; y=355, x=120 → pix_bar=1.

Source files
------------

// File: rtl/note_highway_pkg.sv
// Shared constants, slot record and helpers for the note highway.
//   DEF_*   : default screen / bar / lane geometry
//   slot_t  : one falling-note slot (active flag + top-edge y position)
//   popcount8 : number of set bits in an 8-bit lane mask
package note_highway_pkg;

  localparam int unsigned DEF_Y_W        = 10;
  localparam int unsigned DEF_SCREEN_H   = 480;
  localparam int unsigned DEF_LANE_X0    = 170;
  localparam int unsigned DEF_LANE_PITCH = 100;
  localparam int unsigned DEF_NOTE_W     = 50;
  localparam int unsigned DEF_BAR_Y      = 350;
  localparam int unsigned DEF_BAR_H      = 20;
  localparam int unsigned BAR_MARGIN     = 50;
  localparam int unsigned CNT_W          = 16;

  // Slot position storage is DEF_Y_W bits wide.
  typedef struct packed {
    logic                 active;
    logic [DEF_Y_W-1:0]   pos;
  } slot_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) n = n + 4'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/note_lane.sv
// One lane of falling notes: SLOTS slots with allocate, move/retire,
// strum judgement and pixel hit test.
//   spawn      : write a new note (pos 0) into the lowest free slot
//   judge      : strum with this lane's fret held
//   free_c     : at least one slot is free (current state)
//   hit_c      : judge found an in-window note this cycle
//   falloff_c  : a note crossed SCREEN_H on this frame_tick
//   pix_hit_c  : (x, y) lies inside an active note of this lane
module note_lane
  import note_highway_pkg::*;
#(
  parameter int unsigned SLOTS    = 4,
  parameter int unsigned Y_W      = DEF_Y_W,
  parameter int unsigned SCREEN_H = DEF_SCREEN_H,
  parameter int unsigned NOTE_W   = DEF_NOTE_W,
  parameter int unsigned BAR_Y    = DEF_BAR_Y,
  parameter int unsigned BAR_H    = DEF_BAR_H,
  parameter int unsigned LANE_X   = DEF_LANE_X0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [3:0] speed,
  input  logic       spawn,
  input  logic       judge,
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic       free_c,
  output logic       hit_c,
  output logic       falloff_c,
  output logic       pix_hit_c
);

  localparam int unsigned PW = Y_W + 1;
  localparam int unsigned XW = 11;
  localparam int unsigned IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  slot_t          slot_q [SLOTS];
  slot_t          slot_d [SLOTS];
  logic           found_free;
  logic [IW-1:0]  free_idx;

  // Strum is judged on pre-move positions, survivors move, spawn lands last.
  always_comb begin
    slot_d     = slot_q;
    hit_c      = 1'b0;
    falloff_c  = 1'b0;
    pix_hit_c  = 1'b0;
    found_free = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      logic [PW-1:0] pos_w;
      logic [PW-1:0] sum_w;
      logic          in_win;
      pos_w  = PW'(slot_q[i].pos);
      sum_w  = pos_w + PW'(speed);
      in_win = slot_q[i].active && (pos_w + PW'(NOTE_W) > PW'(BAR_Y)) &&
               (pos_w < PW'(BAR_Y + BAR_H));
      if (!slot_q[i].active && !found_free) begin
        found_free = 1'b1;
        free_idx   = IW'(i);
      end
      if (judge && in_win && !hit_c) begin
        hit_c            = 1'b1;
        slot_d[i].active = 1'b0;
      end else if (slot_q[i].active && frame_tick) begin
        if (sum_w >= PW'(SCREEN_H)) begin
          slot_d[i].active = 1'b0;
          falloff_c        = 1'b1;
        end else begin
          slot_d[i].pos = DEF_Y_W'(sum_w);
        end
      end
      if (slot_q[i].active &&
          (XW'(x) >= XW'(LANE_X)) && (XW'(x) < XW'(LANE_X + NOTE_W)) &&
          (PW'(y) >= pos_w) && (PW'(y) < pos_w + PW'(NOTE_W)))
        pix_hit_c = 1'b1;
    end
    free_c = found_free;
    // The chosen slot is free in the current state, so no hit/move touched it.
    if (spawn && found_free) begin
      slot_d[free_idx].active = 1'b1;
      slot_d[free_idx].pos    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) slot_q[i] <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

endmodule

// File: rtl/note_highway.sv
// Note-lane engine: LANES lanes of falling notes, strum judgement, hit/miss
// reporting with saturating counters, and per-pixel note/bar tags.
//   frame_tick/speed      : move all notes by speed pixels
//   spawn_valid/_lanes    : request a new note in each listed lane
//   spawn_ready           : combinational, every listed lane has a free slot
//   strum/frets           : judge fretted lanes against the hit bar
//   x/y                   : pixel coordinate; pix_* valid one cycle later
//   hit_*/miss_*          : registered one-cycle pulses, masks and counts
module note_highway
  import note_highway_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned SLOTS      = 4,
  parameter int unsigned Y_W        = DEF_Y_W,
  parameter int unsigned SCREEN_H   = DEF_SCREEN_H,
  parameter int unsigned LANE_X0    = DEF_LANE_X0,
  parameter int unsigned LANE_PITCH = DEF_LANE_PITCH,
  parameter int unsigned NOTE_W     = DEF_NOTE_W,
  parameter int unsigned BAR_Y      = DEF_BAR_Y,
  parameter int unsigned BAR_H      = DEF_BAR_H
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic [3:0]        speed,
  input  logic              spawn_valid,
  input  logic [LANES-1:0]  spawn_lanes,
  output logic              spawn_ready,
  input  logic              strum,
  input  logic [LANES-1:0]  frets,
  input  logic [9:0]        x,
  input  logic [8:0]        y,
  output logic              pix_note,
  output logic [2:0]        pix_lane,
  output logic              pix_bar,
  output logic              hit_pulse,
  output logic [LANES-1:0]  hit_mask,
  output logic              miss_pulse,
  output logic [LANES-1:0]  miss_mask,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
);

  localparam int unsigned PW     = Y_W + 1;
  localparam int unsigned XW     = 11;
  localparam int unsigned BAR_X0 = LANE_X0 - BAR_MARGIN;
  localparam int unsigned BAR_X1 = LANE_X0 + (LANES - 1) * LANE_PITCH + NOTE_W + BAR_MARGIN;

  logic [LANES-1:0] free_c, hit_c, falloff_c, pix_hit_c, judge_c, spawn_c;

  logic             hit_pulse_q, hit_pulse_d, miss_pulse_q, miss_pulse_d;
  logic [LANES-1:0] hit_mask_q, hit_mask_d, miss_mask_q, miss_mask_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;
  logic             pix_note_q, pix_note_d, pix_bar_q, pix_bar_d;
  logic [2:0]       pix_lane_q, pix_lane_d;
  logic [CNT_W:0]   hit_sum, miss_sum;

  assign judge_c     = strum ? frets : '0;
  assign spawn_ready = !reset && ((spawn_lanes & ~free_c) == '0);
  assign spawn_c     = (spawn_valid && spawn_ready) ? spawn_lanes : '0;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    note_lane #(
      .SLOTS    (SLOTS),
      .Y_W      (Y_W),
      .SCREEN_H (SCREEN_H),
      .NOTE_W   (NOTE_W),
      .BAR_Y    (BAR_Y),
      .BAR_H    (BAR_H),
      .LANE_X   (LANE_X0 + l * LANE_PITCH)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .frame_tick(frame_tick),
      .speed     (speed),
      .spawn     (spawn_c[l]),
      .judge     (judge_c[l]),
      .x         (x),
      .y         (y),
      .free_c    (free_c[l]),
      .hit_c     (hit_c[l]),
      .falloff_c (falloff_c[l]),
      .pix_hit_c (pix_hit_c[l])
    );
  end

  // Event masks, saturating counters and pixel tags.
  always_comb begin
    hit_mask_d   = hit_c;
    miss_mask_d  = (judge_c & ~hit_c) | falloff_c;
    hit_pulse_d  = |hit_mask_d;
    miss_pulse_d = |miss_mask_d;
    hit_sum      = (CNT_W+1)'(hit_count_q)  + (CNT_W+1)'(popcount8(8'(hit_mask_d)));
    miss_sum     = (CNT_W+1)'(miss_count_q) + (CNT_W+1)'(popcount8(8'(miss_mask_d)));
    hit_count_d  = hit_sum[CNT_W]  ? '1 : hit_sum[CNT_W-1:0];
    miss_count_d = miss_sum[CNT_W] ? '1 : miss_sum[CNT_W-1:0];
    pix_note_d   = |pix_hit_c;
    pix_lane_d   = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if (pix_hit_c[l]) pix_lane_d = 3'(l);
    end
    pix_bar_d = (XW'(x) >= XW'(BAR_X0)) && (XW'(x) < XW'(BAR_X1)) &&
                (PW'(y) >= PW'(BAR_Y)) && (PW'(y) < PW'(BAR_Y + BAR_H));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
      hit_mask_q   <= '0;
      miss_mask_q  <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      pix_note_q   <= 1'b0;
      pix_lane_q   <= '0;
      pix_bar_q    <= 1'b0;
    end else begin
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
      hit_mask_q   <= hit_mask_d;
      miss_mask_q  <= miss_mask_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
      pix_note_q   <= pix_note_d;
      pix_lane_q   <= pix_lane_d;
      pix_bar_q    <= pix_bar_d;
    end
  end

  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;
  assign hit_mask   = hit_mask_q;
  assign miss_mask  = miss_mask_q;
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign pix_note   = pix_note_q;
  assign pix_lane   = pix_lane_q;
  assign pix_bar    = pix_bar_q;

endmodule

// File: tb/tb_note_highway.sv
// Bench for note_highway: directed vector table, randomized run against a
// behavioural model of the lanes, and a counter saturation sequence.
module tb_note_highway;

  localparam int LANES = 4;
  localparam int SLOTS = 4;

  logic       clk = 1'b0;
  logic       reset, frame_tick, spawn_valid, spawn_ready, strum;
  logic [3:0] speed, spawn_lanes, frets;
  logic [9:0] x;
  logic [8:0] y;
  logic       pix_note, pix_bar, hit_pulse, miss_pulse;
  logic [2:0] pix_lane;
  logic [3:0] hit_mask, miss_mask;
  logic [15:0] hit_count, miss_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  note_highway dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .speed(speed),
    .spawn_valid(spawn_valid), .spawn_lanes(spawn_lanes), .spawn_ready(spawn_ready),
    .strum(strum), .frets(frets), .x(x), .y(y),
    .pix_note(pix_note), .pix_lane(pix_lane), .pix_bar(pix_bar),
    .hit_pulse(hit_pulse), .hit_mask(hit_mask), .miss_pulse(miss_pulse),
    .miss_mask(miss_mask), .hit_count(hit_count), .miss_count(miss_count)
  );

  // Model: per-lane note slots plus expected registered outputs.
  bit         m_act [LANES][SLOTS];
  int         m_pos [LANES][SLOTS];
  int         m_hc, m_mc;
  logic [3:0] m_hm, m_mm;
  logic       m_pn, m_pb;
  logic [2:0] m_pl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive, check spawn_ready, advance model, check outputs.
  task automatic cyc(input logic rst, input logic sv, input logic [3:0] sl, input logic st,
                     input logic [3:0] fr, input logic ft, input logic [3:0] sp,
                     input logic [9:0] xx, input logic [8:0] yy, output logic rdy);
    int fs [LANES];
    logic [3:0] hm, mm;
    reset = rst; spawn_valid = sv; spawn_lanes = sl; strum = st; frets = fr;
    frame_tick = ft; speed = sp; x = xx; y = yy;
    #1;
    rdy = !rst;
    for (int l = 0; l < LANES; l++) begin
      fs[l] = -1;
      for (int s = SLOTS - 1; s >= 0; s--) if (!m_act[l][s]) fs[l] = s;
      if (sl[l] && fs[l] < 0) rdy = 1'b0;
    end
    check("spawn_ready", 32'(spawn_ready), 32'(rdy));
    m_pn = 1'b0; m_pl = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (m_act[l][s] && int'(xx) >= 170 + 100 * l && int'(xx) < 220 + 100 * l &&
            int'(yy) >= m_pos[l][s] && int'(yy) < m_pos[l][s] + 50) begin
          m_pn = 1'b1; m_pl = 3'(l);
        end
      end
    end
    m_pb = int'(xx) >= 120 && int'(xx) < 570 && int'(yy) >= 350 && int'(yy) < 370;
    if (rst) begin
      for (int l = 0; l < LANES; l++) for (int s = 0; s < SLOTS; s++) m_act[l][s] = 0;
      m_hc = 0; m_mc = 0; m_hm = '0; m_mm = '0; m_pn = 1'b0; m_pl = '0; m_pb = 1'b0;
    end else begin
      hm = '0; mm = '0;
      for (int l = 0; l < LANES; l++) begin
        if (st && fr[l]) begin
          int hs;
          hs = -1;
          for (int s = SLOTS - 1; s >= 0; s--)
            if (m_act[l][s] && m_pos[l][s] + 50 > 350 && m_pos[l][s] < 370) hs = s;
          if (hs >= 0) begin m_act[l][hs] = 0; hm[l] = 1'b1; end
          else mm[l] = 1'b1;
        end
      end
      if (ft) begin
        for (int l = 0; l < LANES; l++) begin
          for (int s = 0; s < SLOTS; s++) begin
            if (m_act[l][s]) begin
              if (m_pos[l][s] + int'(sp) >= 480) begin m_act[l][s] = 0; mm[l] = 1'b1; end
              else m_pos[l][s] = m_pos[l][s] + int'(sp);
            end
          end
        end
      end
      if (sv && rdy) begin
        for (int l = 0; l < LANES; l++)
          if (sl[l]) begin m_act[l][fs[l]] = 1; m_pos[l][fs[l]] = 0; end
      end
      m_hm = hm; m_mm = mm;
      m_hc = m_hc + $countones(hm); if (m_hc > 65535) m_hc = 65535;
      m_mc = m_mc + $countones(mm); if (m_mc > 65535) m_mc = 65535;
    end
    @(posedge clk); #1;
    check("hit_pulse",  32'(hit_pulse),  32'(|m_hm));
    check("hit_mask",   32'(hit_mask),   32'(m_hm));
    check("miss_pulse", 32'(miss_pulse), 32'(|m_mm));
    check("miss_mask",  32'(miss_mask),  32'(m_mm));
    check("hit_count",  32'(hit_count),  32'(m_hc));
    check("miss_count", 32'(miss_count), 32'(m_mc));
    check("pix_note",   32'(pix_note),   32'(m_pn));
    if (m_pn) check("pix_lane", 32'(pix_lane), 32'(m_pl));
    check("pix_bar",    32'(pix_bar),    32'(m_pb));
  endtask

  typedef struct {
    logic sv; logic [3:0] sl; logic st; logic [3:0] fr; logic ft; logic [3:0] sp;
    logic [9:0] x; logic [8:0] y; int reps;
    logic e_rdy; logic [3:0] e_hit; logic [3:0] e_miss;
    logic e_pn; logic [2:0] e_pl; logic e_pb; int e_hc; int e_mc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic sv, input logic [3:0] sl, input logic st,
      input logic [3:0] fr, input logic ft, input logic [3:0] sp, input int xx, input int yy,
      input int reps, input logic rdy, input logic [3:0] eh, input logic [3:0] em,
      input logic pn, input int pl, input logic pb, input int hc, input int mc);
    vec_t v;
    v.sv = sv; v.sl = sl; v.st = st; v.fr = fr; v.ft = ft; v.sp = sp;
    v.x = 10'(xx); v.y = 9'(yy); v.reps = reps;
    v.e_rdy = rdy; v.e_hit = eh; v.e_miss = em; v.e_pn = pn; v.e_pl = 3'(pl);
    v.e_pb = pb; v.e_hc = hc; v.e_mc = mc;
    tbl.push_back(v);
  endfunction

  initial begin
    logic rdy;
    // sv sl st fr ft sp x y reps | rdy hit miss pn pl pb hc mc
    add(1, 4'b0001, 0, 4'b0000, 0,  0,   0,   0,  1, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 1,  5,   0,   0, 70, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 0,  0, 170, 350,  1, 1, 4'b0000, 4'b0000, 1, 0, 1, 0, 0);
    add(0, 4'b0000, 0, 4'b0000, 0,  0, 170, 349,  1, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 0);
    add(0, 4'b0000, 1, 4'b0001, 0,  0,   0,   0,  1, 1, 4'b0001, 4'b0000, 0, 0, 0, 1, 0);
    add(0, 4'b0000, 0, 4'b0000, 0,  0, 170, 350,  1, 1, 4'b0000, 4'b0000, 0, 0, 1, 1, 0);
    add(0, 4'b0000, 1, 4'b0010, 0,  0,   0,   0,  1, 1, 4'b0000, 4'b0010, 0, 0, 0, 1, 1);
    add(1, 4'b0010, 0, 4'b0000, 0,  0,   0,   0,  1, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, 1);
    add(0, 4'b0000, 0, 4'b0000, 1, 15,   0,   0,  6, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, 1);
    add(0, 4'b0000, 0, 4'b0000, 1,  5,   0,   0,  2, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, 1);
    add(0, 4'b0000, 0, 4'b0000, 0,  0, 270, 100,  1, 1, 4'b0000, 4'b0000, 1, 1, 0, 1, 1);
    add(0, 4'b0000, 0, 4'b0000, 0,  0, 320, 100,  1, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, 1);
    add(0, 4'b0000, 0, 4'b0000, 0,  0, 319, 149,  1, 1, 4'b0000, 4'b0000, 1, 1, 0, 1, 1);
    add(0, 4'b0000, 0, 4'b0000, 0,  0, 270, 150,  1, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, 1);
    add(0, 4'b0000, 0, 4'b0000, 0,  0, 120, 355,  1, 1, 4'b0000, 4'b0000, 0, 0, 1, 1, 1);
    add(0, 4'b0000, 0, 4'b0000, 0,  0, 119, 355,  1, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, 1);
    add(0, 4'b0000, 0, 4'b0000, 0,  0, 569, 369,  1, 1, 4'b0000, 4'b0000, 0, 0, 1, 1, 1);
    add(0, 4'b0000, 0, 4'b0000, 0,  0, 570, 355,  1, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, 1);
    add(0, 4'b0000, 0, 4'b0000, 0,  0, 300, 370,  1, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, 1);
    add(0, 4'b0000, 0, 4'b0000, 1, 15,   0,   0, 17, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, 1);
    add(0, 4'b0000, 0, 4'b0000, 1, 10,   0,   0,  1, 1, 4'b0000, 4'b0000, 0, 0, 0, 1, 1);
    add(0, 4'b0000, 1, 4'b0010, 1,  5,   0,   0,  1, 1, 4'b0010, 4'b0000, 0, 0, 0, 2, 1);
    add(0, 4'b0000, 0, 4'b0000, 0,  0, 270, 375,  1, 1, 4'b0000, 4'b0000, 0, 0, 0, 2, 1);
    add(1, 4'b1000, 0, 4'b0000, 0,  0,   0,   0,  1, 1, 4'b0000, 4'b0000, 0, 0, 0, 2, 1);
    add(0, 4'b0000, 0, 4'b0000, 1,  7,   0,   0, 19, 1, 4'b0000, 4'b0000, 0, 0, 0, 2, 1);
    add(1, 4'b0001, 0, 4'b0000, 0,  0,   0,   0,  1, 1, 4'b0000, 4'b0000, 0, 0, 0, 2, 1);
    add(0, 4'b0000, 0, 4'b0000, 1, 15,   0,   0, 23, 1, 4'b0000, 4'b0000, 0, 0, 0, 2, 1);
    add(0, 4'b0000, 0, 4'b0000, 0,  0, 470, 478,  1, 1, 4'b0000, 4'b0000, 1, 3, 0, 2, 1);
    add(0, 4'b0000, 1, 4'b0001, 1,  5,   0,   0,  1, 1, 4'b0001, 4'b1000, 0, 0, 0, 3, 2);
    add(1, 4'b0100, 0, 4'b0000, 0,  0,   0,   0,  4, 1, 4'b0000, 4'b0000, 0, 0, 0, 3, 2);
    add(1, 4'b0100, 0, 4'b0000, 0,  0,   0,   0,  2, 0, 4'b0000, 4'b0000, 0, 0, 0, 3, 2);
    add(1, 4'b0001, 0, 4'b0000, 0,  0,   0,   0,  1, 1, 4'b0000, 4'b0000, 0, 0, 0, 3, 2);
    add(1, 4'b0101, 0, 4'b0000, 0,  0,   0,   0,  1, 0, 4'b0000, 4'b0000, 0, 0, 0, 3, 2);
    add(1, 4'b0000, 0, 4'b0000, 0,  0,   0,   0,  1, 1, 4'b0000, 4'b0000, 0, 0, 0, 3, 2);
    add(0, 4'b0000, 1, 4'b0000, 0,  0,   0,   0,  1, 1, 4'b0000, 4'b0000, 0, 0, 0, 3, 2);
    add(0, 4'b0000, 1, 4'b1111, 0,  0,   0,   0,  1, 1, 4'b0000, 4'b1111, 0, 0, 0, 3, 6);
    add(0, 4'b0000, 0, 4'b0000, 1, 15,   0,   0, 31, 1, 4'b0000, 4'b0000, 0, 0, 0, 3, 6);
    add(0, 4'b0000, 0, 4'b0000, 1, 15,   0,   0,  1, 1, 4'b0000, 4'b0101, 0, 0, 0, 3, 8);
    add(1, 4'b0100, 0, 4'b0000, 0,  0,   0,   0,  1, 1, 4'b0000, 4'b0000, 0, 0, 0, 3, 8);

    @(posedge clk); #1;

    // Reset: spawn_ready low while reset is high, all outputs cleared.
    repeat (2) begin
      cyc(1, 1, 4'b0001, 0, 4'b0000, 0, 4'd0, 10'd0, 9'd0, rdy);
      check("rst_ready", 32'(rdy), 32'(0));
    end
    check("rst_hit_count", 32'(hit_count), 32'(0));
    check("rst_miss_mask", 32'(miss_mask), 32'(0));

    // Directed vectors; hand expectations apply to the last repetition.
    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++)
        cyc(0, tbl[i].sv, tbl[i].sl, tbl[i].st, tbl[i].fr, tbl[i].ft, tbl[i].sp,
            tbl[i].x, tbl[i].y, rdy);
      check($sformatf("v%0d_ready", i), 32'(rdy), 32'(tbl[i].e_rdy));
      check($sformatf("v%0d_hit_mask", i), 32'(hit_mask), 32'(tbl[i].e_hit));
      check($sformatf("v%0d_miss_mask", i), 32'(miss_mask), 32'(tbl[i].e_miss));
      check($sformatf("v%0d_pix_note", i), 32'(pix_note), 32'(tbl[i].e_pn));
      if (tbl[i].e_pn) check($sformatf("v%0d_pix_lane", i), 32'(pix_lane), 32'(tbl[i].e_pl));
      check($sformatf("v%0d_pix_bar", i), 32'(pix_bar), 32'(tbl[i].e_pb));
      check($sformatf("v%0d_hit_count", i), 32'(hit_count), 32'(tbl[i].e_hc));
      check($sformatf("v%0d_miss_count", i), 32'(miss_count), 32'(tbl[i].e_mc));
    end

    // Reset with notes present and a strum pending: no miss reported.
    cyc(1, 0, 4'b0000, 1, 4'b1111, 1, 4'd15, 10'd0, 9'd0, rdy);
    check("midreset_miss_mask", 32'(miss_mask), 32'(0));
    check("midreset_miss_count", 32'(miss_count), 32'(0));

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), 4'($urandom),
          ($urandom_range(0, 3) == 0), 4'($urandom), ($urandom_range(0, 1) == 1),
          4'($urandom), 10'($urandom_range(100, 600)), 9'($urandom_range(0, 479)), rdy);
    end

    // Miss counter saturation.
    cyc(1, 0, 4'b0000, 0, 4'b0000, 0, 4'd0, 10'd0, 9'd0, rdy);
    for (int n = 0; n < 16383; n++)
      cyc(0, 0, 4'b0000, 1, 4'b1111, 0, 4'd0, 10'd0, 9'd0, rdy);
    check("sat_fffc", 32'(miss_count), 32'h0000_FFFC);
    cyc(0, 0, 4'b0000, 1, 4'b0011, 0, 4'd0, 10'd0, 9'd0, rdy);
    check("sat_fffe", 32'(miss_count), 32'h0000_FFFE);
    cyc(0, 0, 4'b0000, 1, 4'b0011, 0, 4'd0, 10'd0, 9'd0, rdy);
    check("sat_ffff", 32'(miss_count), 32'h0000_FFFF);
    check("sat_pulse", 32'(miss_pulse), 32'(1));
    cyc(0, 0, 4'b0000, 1, 4'b0001, 0, 4'd0, 10'd0, 9'd0, rdy);
    check("sat_hold", 32'(miss_count), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
